// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between pipeline stages and the pipeline controller.
// The controller (slave) consumes stall requests and exception info and returns hold/flush/redirect.
interface pipeline_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  // mc_start is a single-cycle request: it is accepted only when the controller is idle and
  // no exception is present in the same cycle; otherwise it is dropped and must be reissued.
  logic        mc_start;
  logic [5:0]  mc_cycles;
  logic [31:0] exceptionType_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mc_busy;
  logic        mc_done;
  logic [1:0]  state_dbg;

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  mc_start, mc_cycles, exceptionType_i, cp0_epc_i,
    output stall, flush, new_pc, mc_busy, mc_done, state_dbg
  );

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output mc_start, mc_cycles, exceptionType_i, cp0_epc_i,
    input  stall, flush, new_pc, mc_busy, mc_done, state_dbg
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: prioritised stage stalls, multi-cycle EX sequencing
// and exception flush/redirect with a one-cycle recovery state.
module pipeline_ctrl (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_MC_RUN     = 2'd1;
  localparam logic [1:0] S_FLUSH_WAIT = 2'd2;

  logic [1:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       exc_present;
  logic       cnt_nz;
  logic       flush_c;
  logic       mc_stall;
  logic [5:0] n_eff;

  always_comb begin
    exc_present = |bus.exceptionType_i;
    cnt_nz      = |cnt_q;
    flush_c     = !rst && exc_present && (state_q != S_FLUSH_WAIT);
    mc_stall    = ((state_q == S_IDLE) && bus.mc_start) ||
                  ((state_q == S_MC_RUN) && cnt_nz);
    n_eff       = (bus.mc_cycles == 6'd0) ? 6'd1 : bus.mc_cycles;
  end

  // An exception zeroes stall so the flush reaches every stage, including the ones it would hold.
  always_comb begin
    bus.stall = 6'b000000;
    if (rst || (state_q == S_FLUSH_WAIT) || exc_present)
      bus.stall = 6'b000000;
    else if (bus.stallreq_mem)
      bus.stall = 6'b011111;
    else if (bus.stallreq_ex || mc_stall)
      bus.stall = 6'b001111;
    else if (bus.stallreq_id)
      bus.stall = 6'b000111;
    else if (bus.stallreq_if)
      bus.stall = 6'b000011;
  end

  always_comb begin
    bus.flush  = flush_c;
    bus.new_pc = 32'h0;
    if (flush_c)
      bus.new_pc = (bus.exceptionType_i == 32'h0000000e) ? bus.cp0_epc_i : 32'hBFC00380;
    bus.mc_busy   = !rst && (state_q == S_MC_RUN) && cnt_nz;
    bus.mc_done   = !rst && (state_q == S_MC_RUN) && !cnt_nz && !flush_c;
    bus.state_dbg = state_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_c) begin
      state_d = S_FLUSH_WAIT;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.mc_start) begin
            state_d = S_MC_RUN;
            cnt_d   = n_eff - 6'd1;
          end
        end
        S_MC_RUN: begin
          if (cnt_nz) cnt_d = cnt_q - 6'd1;
          else        state_d = S_IDLE;
        end
        S_FLUSH_WAIT: begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, input, 1 each, stage stall requests.
REQ-004 SHALL have port mc_start, input, 1, EX stage begins a multi-cycle op (mul/div).
REQ-005 SHALL have port mc_cycles, input, 6, op latency N; value 0 treated as 1.
REQ-006 SHALL have port exceptionType_i, input, 32, exception code from MEM; 0 = none.
REQ-007 SHALL have port cp0_epc_i, input, 32, CP0 EPC value.
REQ-008 SHALL have port stall, output, 6, per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-009 SHALL have port flush, output, 1, clear all pipeline registers this cycle.
REQ-010 SHALL have port new_pc, output, 32, redirect target, valid when flush=1.
REQ-011 SHALL have ports mc_busy and mc_done, output, 1 each, multi-cycle status.

Function
REQ-012 SHALL run a state machine with states IDLE, MC_RUN and FLUSH_WAIT, plus a 6-bit down-counter cnt.
REQ-013 In IDLE with mc_start=1, SHALL load cnt=N-1 and go to MC_RUN at the next edge.
REQ-014 In MC_RUN with cnt!=0, SHALL decrement cnt each cycle.
REQ-015 In MC_RUN with cnt=0, SHALL assert mc_done for exactly that cycle and return to IDLE.
REQ-016 SHALL assert mc_busy while state=MC_RUN and cnt!=0.
REQ-017 SHALL raise the internal request mc_stall when (IDLE and mc_start) or (MC_RUN and cnt!=0), giving exactly N stalled cycles followed by mc_done in cycle N.
REQ-018 SHALL ignore mc_start outside IDLE.
REQ-019 SHALL drive stall combinationally, highest priority first:
- exception: 6'b000000
- stallreq_mem: 6'b011111
- stallreq_ex or mc_stall: 6'b001111
- stallreq_id: 6'b000111
- stallreq_if: 6'b000011
- otherwise: 6'b000000
REQ-020 SHALL assert flush combinationally when exceptionType_i!=0 and state!=FLUSH_WAIT.
REQ-021 When flush=1 and exceptionType_i=32'h0000000e (eret), SHALL drive new_pc=cp0_epc_i.
REQ-022 When flush=1 for any other nonzero code, SHALL drive new_pc=32'hBFC00380.
REQ-023 When flush=0, SHALL drive new_pc=32'h0.
REQ-024 On flush, SHALL go to FLUSH_WAIT at the next edge from any state, aborting MC_RUN: cnt cleared, no mc_done.
REQ-025 In FLUSH_WAIT, SHALL hold flush=0 and stall=0, ignore mc_start and exceptions, and return to IDLE after one cycle.
REQ-026 When an exception and mc_start occur in the same cycle, SHALL let the exception win and not start the multi-cycle op.
REQ-027 When stallreq_mem coincides with MC_RUN, SHALL output 6'b011111 while cnt keeps counting.

Reset
REQ-028 While rst=1, SHALL immediately (asynchronously) hold state=IDLE, cnt=0, mc_busy=0, mc_done=0.
REQ-029 While rst=1, SHALL force stall=0, flush=0 and new_pc=0 regardless of inputs.
REQ-030 A reset asserted mid-MC_RUN or in FLUSH_WAIT SHALL abandon the operation with no mc_done pulse.

Verification
REQ-031 Bench SHALL cover: stallreq_id=1 alone -> stall=000111; stallreq_id=1 with stallreq_mem=1 -> 011111.
REQ-032 Bench SHALL cover: mc_start with mc_cycles=4 -> stall=001111 in cycles 0-3, mc_busy in cycles 1-3, mc_done=1 in cycle 4 with stall=000000.
REQ-033 Bench SHALL cover: mc_start with mc_cycles=0 -> stall for 1 cycle, mc_done in cycle 1.
REQ-034 Bench SHALL cover: exceptionType_i=32'h8 during MC_RUN (cnt=2) -> flush=1, new_pc=BFC00380, stall=0; next cycle FLUSH_WAIT, no mc_done, then IDLE.
REQ-035 Bench SHALL cover: exceptionType_i=32'he with cp0_epc_i=32'h00400120 -> flush=1, new_pc=00400120 for one cycle; a held exception is not re-flushed in FLUSH_WAIT.
REQ-036 Bench SHALL cover: rst asserted between edges mid-MC_RUN -> outputs zero immediately; after release, mc_start restarts counting from N.
